// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: access type codes, funct3
// width codes, FSM state encoding, the IO region marker, and a helper that
// maps a width code to the number of byte cycles needed.
package mem_ctrl_pkg;

    localparam logic [6:0] LD_TYPE = 7'b0000011;
    localparam logic [6:0] S_TYPE  = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // addr[17:16] value that selects the memory-mapped IO window
    localparam logic [1:0] IO_REGION_HI = 2'b11;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_state_t;

    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            2'b00:   byte_count = 3'd1;
            2'b01:   byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Combinational load extension.
//   op  : funct3 width/sign code of the load
//   raw : little-endian assembled bus word (unused upper bytes ignored)
//   ext : sign- or zero-extended 32-bit result
module mem_load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        case (op)
            F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  ext = {24'd0, raw[7:0]};
            F3_LHU:  ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: sole owner of the byte-serial RAM/IO bus.
// Arbitrates round-robin between instruction fetch and the load/store
// buffer, sequences each access into byte cycles, assembles/extends load
// data and returns a one-cycle completion pulse to the winner.
//   clk, rst (async, active low), rdy (global freeze when 0), rob_clear
//   io_buffer_full : stalls stores into the IO window
//   mem_din/mem_dout/mem_a/mem_wr : byte-serial bus
//   ifetch_req/ifetch_addr -> ifetch_ready/ifetch_data
//   in_lsb_ready/op_in/instr_type_in/data_addr_in/data_in
//       -> welcome_lsb, cache_ready/cache_instr_type/cache_data_out
//
// state     | meaning
// MEM_IDLE  | bus quiet, arbitration takes place at the next edge
// MEM_READ  | issuing byte addresses and collecting returned bytes
// MEM_WRITE | driving store bytes, possibly stalled by the IO buffer
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_HI_BITS = IO_REGION_HI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rob_clear,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_addr,
    output logic        ifetch_ready,
    output logic [31:0] ifetch_data,
    output logic        welcome_lsb,
    input  logic        in_lsb_ready,
    input  logic [2:0]  op_in,
    input  logic [6:0]  instr_type_in,
    input  logic [31:0] data_addr_in,
    input  logic [31:0] data_in,
    output logic        cache_ready,
    output logic [6:0]  cache_instr_type,
    output logic [31:0] cache_data_out
);

    mem_state_t  state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic        last_lsb, last_lsb_n;
    logic        serve_lsb, serve_lsb_n;
    logic [31:0] addr_q, addr_n;
    logic [2:0]  op_q, op_n;
    logic [6:0]  type_q, type_n;
    logic [31:0] wdata_q, wdata_n;
    logic [31:0] buf_q, buf_n;

    logic [7:0]  mem_dout_n;
    logic [31:0] mem_a_n;
    logic        mem_wr_n;
    logic        ifetch_ready_n;
    logic [31:0] ifetch_data_n;
    logic        welcome_n;
    logic        cache_ready_n;
    logic [6:0]  cache_type_n;
    logic [31:0] cache_data_n;

    logic        pick_lsb;
    logic        g_store;
    logic        g_stall;
    logic [2:0]  nb;
    logic [1:0]  cap_sel;
    logic [31:0] word_cap;
    logic [31:0] ext_word;
    logic        io_region;

    // ifetch latches op_q = LW, so the same byte count covers both requesters
    assign nb        = byte_count(op_q[1:0]);
    assign io_region = (addr_q[17:16] == IO_HI_BITS);

    // At READ step cnt the byte returning on mem_din belongs to index cnt-2.
    // word_cap is the buffer with that byte merged, so the completing edge
    // can hand out the full word without an extra cycle.
    assign cap_sel = 2'(cnt - 3'd2);
    always_comb begin
        word_cap = buf_q;
        word_cap[{cap_sel, 3'b000} +: 8] = mem_din;
    end

    mem_load_ext u_ext (
        .op  (op_q),
        .raw (word_cap),
        .ext (ext_word)
    );

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        last_lsb_n     = last_lsb;
        serve_lsb_n    = serve_lsb;
        addr_n         = addr_q;
        op_n           = op_q;
        type_n         = type_q;
        wdata_n        = wdata_q;
        buf_n          = buf_q;
        mem_a_n        = mem_a;
        mem_dout_n     = mem_dout;
        mem_wr_n       = mem_wr;
        ifetch_ready_n = 1'b0;
        ifetch_data_n  = ifetch_data;
        cache_ready_n  = 1'b0;
        cache_type_n   = cache_instr_type;
        cache_data_n   = cache_data_out;
        pick_lsb       = 1'b0;
        g_store        = 1'b0;
        g_stall        = 1'b0;

        case (state)
            MEM_IDLE: begin
                if (!rob_clear && (ifetch_req || in_lsb_ready)) begin
                    // LSB wins when alone, or when fetch had the last grant
                    pick_lsb    = in_lsb_ready && (!ifetch_req || !last_lsb);
                    serve_lsb_n = pick_lsb;
                    last_lsb_n  = pick_lsb;
                    buf_n       = '0;
                    cnt_n       = 3'd1;
                    if (pick_lsb) begin
                        addr_n  = data_addr_in;
                        op_n    = op_in;
                        type_n  = instr_type_in;
                        wdata_n = data_in;
                        g_store = (instr_type_in == S_TYPE);
                        g_stall = g_store && io_buffer_full &&
                                  (data_addr_in[17:16] == IO_HI_BITS);
                    end else begin
                        addr_n  = ifetch_addr;
                        op_n    = F3_LW;
                        type_n  = '0;
                    end
                    mem_a_n = addr_n;
                    if (g_store) begin
                        state_n    = MEM_WRITE;
                        mem_dout_n = data_in[7:0];
                        mem_wr_n   = !g_stall;
                        cnt_n      = g_stall ? 3'd0 : 3'd1;
                    end else begin
                        state_n  = MEM_READ;
                        mem_wr_n = 1'b0;
                    end
                end
            end

            MEM_READ: begin
                if (rob_clear) begin
                    state_n  = MEM_IDLE;
                    cnt_n    = 3'd0;
                    mem_a_n  = '0;
                    mem_wr_n = 1'b0;
                end else if (cnt == 3'(nb + 3'd1)) begin
                    state_n = MEM_IDLE;
                    cnt_n   = 3'd0;
                    mem_a_n = '0;
                    buf_n   = word_cap;
                    if (serve_lsb) begin
                        cache_ready_n = 1'b1;
                        cache_type_n  = type_q;
                        cache_data_n  = ext_word;
                    end else begin
                        ifetch_ready_n = 1'b1;
                        ifetch_data_n  = word_cap;
                    end
                end else begin
                    if (cnt >= 3'd2)
                        buf_n = word_cap;
                    if (cnt < nb)
                        mem_a_n = addr_q + {29'd0, cnt};
                    cnt_n = cnt + 3'd1;
                end
            end

            MEM_WRITE: begin
                if (cnt == nb) begin
                    state_n       = MEM_IDLE;
                    cnt_n         = 3'd0;
                    mem_a_n       = '0;
                    mem_dout_n    = '0;
                    mem_wr_n      = 1'b0;
                    cache_ready_n = 1'b1;
                    cache_type_n  = type_q;
                    cache_data_n  = '0;
                end else if (io_region && io_buffer_full) begin
                    mem_wr_n = 1'b0;
                end else begin
                    mem_a_n    = addr_q + {29'd0, cnt};
                    mem_dout_n = wdata_q[{cnt[1:0], 3'b000} +: 8];
                    mem_wr_n   = 1'b1;
                    cnt_n      = cnt + 3'd1;
                end
            end

            default: begin
                state_n  = MEM_IDLE;
                cnt_n    = 3'd0;
                mem_wr_n = 1'b0;
            end
        endcase

        welcome_n = (state_n == MEM_IDLE) && !rob_clear;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= MEM_IDLE;
            cnt              <= 3'd0;
            last_lsb         <= 1'b0;
            serve_lsb        <= 1'b0;
            addr_q           <= '0;
            op_q             <= '0;
            type_q           <= '0;
            wdata_q          <= '0;
            buf_q            <= '0;
            mem_a            <= '0;
            mem_dout         <= '0;
            mem_wr           <= 1'b0;
            ifetch_ready     <= 1'b0;
            ifetch_data      <= '0;
            welcome_lsb      <= 1'b0;
            cache_ready      <= 1'b0;
            cache_instr_type <= '0;
            cache_data_out   <= '0;
        end else if (rdy) begin
            state            <= state_n;
            cnt              <= cnt_n;
            last_lsb         <= last_lsb_n;
            serve_lsb        <= serve_lsb_n;
            addr_q           <= addr_n;
            op_q             <= op_n;
            type_q           <= type_n;
            wdata_q          <= wdata_n;
            buf_q            <= buf_n;
            mem_a            <= mem_a_n;
            mem_dout         <= mem_dout_n;
            mem_wr           <= mem_wr_n;
            ifetch_ready     <= ifetch_ready_n;
            ifetch_data      <= ifetch_data_n;
            welcome_lsb      <= welcome_n;
            cache_ready      <= cache_ready_n;
            cache_instr_type <= cache_type_n;
            cache_data_out   <= cache_data_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a small registered-read RAM model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rob_clear = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        ifetch_req = 1'b0;
    logic [31:0] ifetch_addr = 32'd0;
    logic        ifetch_ready;
    logic [31:0] ifetch_data;
    logic        welcome_lsb;
    logic        in_lsb_ready = 1'b0;
    logic [2:0]  op_in = 3'd0;
    logic [6:0]  instr_type_in = 7'd0;
    logic [31:0] data_addr_in = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic        cache_ready;
    logic [6:0]  cache_instr_type;
    logic [31:0] cache_data_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ram [0:4095];

    mem_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .rob_clear        (rob_clear),
        .io_buffer_full   (io_buffer_full),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .ifetch_req       (ifetch_req),
        .ifetch_addr      (ifetch_addr),
        .ifetch_ready     (ifetch_ready),
        .ifetch_data      (ifetch_data),
        .welcome_lsb      (welcome_lsb),
        .in_lsb_ready     (in_lsb_ready),
        .op_in            (op_in),
        .instr_type_in    (instr_type_in),
        .data_addr_in     (data_addr_in),
        .data_in          (data_in),
        .cache_ready      (cache_ready),
        .cache_instr_type (cache_instr_type),
        .cache_data_out   (cache_data_out)
    );

    always #5 clk = ~clk;

    // RAM: data for an address appears on mem_din one cycle later
    always @(posedge clk) begin
        if (mem_wr)
            ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch with both requests' address sequence and result checked.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        ifetch_req  = 1'b1;
        ifetch_addr = addr;
        tick();
        chk({tag, "_a0"}, mem_a, addr);
        chk({tag, "_wr"}, {31'd0, mem_wr}, 32'd0);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk({tag, "_a"}, mem_a, addr + 32'(e));
        end
        tick();
        chk({tag, "_rdy4"}, {31'd0, ifetch_ready}, 32'd0);
        tick();
        chk({tag, "_rdy5"}, {31'd0, ifetch_ready}, 32'd1);
        chk({tag, "_data"}, ifetch_data, exp);
        ifetch_req = 1'b0;
    endtask

    // LSB load; returns just after the completion edge (pulse still high).
    task automatic lsb_load(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] exp, input string tag);
        int n;
        n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        in_lsb_ready  = 1'b1;
        op_in         = op;
        instr_type_in = LD_TYPE;
        data_addr_in  = addr;
        tick();
        chk({tag, "_a0"}, mem_a, addr);
        in_lsb_ready = 1'b0;
        op_in        = 3'd7;
        data_addr_in = 32'hFFFF_0000;
        for (int e = 1; e <= n; e++) tick();
        chk({tag, "_early"}, {31'd0, cache_ready}, 32'd0);
        tick();
        chk({tag, "_rdy"}, {31'd0, cache_ready}, 32'd1);
        chk({tag, "_data"}, cache_data_out, exp);
        chk({tag, "_type"}, {25'd0, cache_instr_type}, {25'd0, LD_TYPE});
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
        ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h200] = 8'h80; ram[12'h201] = 8'h7F;
        ram[12'h202] = 8'h34; ram[12'h203] = 8'hF2;
        ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22;
        ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;

        #1 rst = 1'b0;
        #1;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_welcome", {31'd0, welcome_lsb}, 32'd0);
        chk("rst_cache_rdy", {31'd0, cache_ready}, 32'd0);
        chk("rst_if_data", ifetch_data, 32'd0);
        #10 rst = 1'b1;
        tick();
        chk("idle_welcome", {31'd0, welcome_lsb}, 32'd1);

        // instruction fetch
        fetch(32'h100, 32'h0000_0513, "if1");
        tick();
        chk("if1_pulse_end", {31'd0, ifetch_ready}, 32'd0);
        chk("if1_hold", ifetch_data, 32'h0000_0513);

        // loads and extension
        lsb_load(F3_LB,  32'h200, 32'hFFFF_FF80, "lb");
        lsb_load(F3_LBU, 32'h200, 32'h0000_0080, "lbu");
        lsb_load(F3_LW,  32'h200, 32'hF234_7F80, "lw");
        lsb_load(F3_LHU, 32'h202, 32'h0000_F234, "lhu");
        lsb_load(F3_LH,  32'h202, 32'hFFFF_F234, "lh_neg");
        lsb_load(F3_LH,  32'h200, 32'h0000_7F80, "lh");
        // rdy=0 stretches the completion pulse
        rdy = 1'b0;
        tick(); tick();
        chk("frz_rdy", {31'd0, cache_ready}, 32'd1);
        chk("frz_data", cache_data_out, 32'h0000_7F80);
        rdy = 1'b1;
        tick();
        chk("frz_release", {31'd0, cache_ready}, 32'd0);
        chk("frz_hold", cache_data_out, 32'h0000_7F80);

        // SH
        in_lsb_ready = 1'b1; op_in = F3_SH; instr_type_in = S_TYPE;
        data_addr_in = 32'h300; data_in = 32'hDEAD_BEEF;
        tick();
        in_lsb_ready = 1'b0; data_in = 32'h0;
        chk("sh0_a", mem_a, 32'h300);
        chk("sh0_d", {24'd0, mem_dout}, 32'hEF);
        chk("sh0_wr", {31'd0, mem_wr}, 32'd1);
        tick();
        chk("sh1_a", mem_a, 32'h301);
        chk("sh1_d", {24'd0, mem_dout}, 32'hBE);
        chk("sh1_wr", {31'd0, mem_wr}, 32'd1);
        tick();
        chk("sh_end_wr", {31'd0, mem_wr}, 32'd0);
        chk("sh_rdy", {31'd0, cache_ready}, 32'd1);
        chk("sh_data", cache_data_out, 32'd0);
        chk("sh_type", {25'd0, cache_instr_type}, {25'd0, S_TYPE});
        chk("sh_ram", {24'd0, ram[12'h301]}, 32'hBE);

        // rob_clear aborts an LW on its third cycle
        in_lsb_ready = 1'b1; op_in = F3_LW; instr_type_in = LD_TYPE;
        data_addr_in = 32'h200;
        tick();
        in_lsb_ready = 1'b0;
        tick(); tick();
        rob_clear = 1'b1;
        tick();
        chk("abort_a", mem_a, 32'd0);
        chk("abort_welcome", {31'd0, welcome_lsb}, 32'd0);
        rob_clear = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            chk("abort_no_rdy", {31'd0, cache_ready}, 32'd0);
        end

        // rob_clear is ignored by an SW in progress
        in_lsb_ready = 1'b1; op_in = F3_SW; instr_type_in = S_TYPE;
        data_addr_in = 32'h310; data_in = 32'h1122_3344;
        tick();
        in_lsb_ready = 1'b0;
        rob_clear = 1'b1;
        chk("sw0_d", {24'd0, mem_dout}, 32'h44);
        tick(); chk("sw1_a", mem_a, 32'h311); chk("sw1_d", {24'd0, mem_dout}, 32'h33);
        tick(); chk("sw2_d", {24'd0, mem_dout}, 32'h22);
        tick(); chk("sw3_a", mem_a, 32'h313); chk("sw3_d", {24'd0, mem_dout}, 32'h11);
        chk("sw3_wr", {31'd0, mem_wr}, 32'd1);
        tick();
        chk("sw_rdy", {31'd0, cache_ready}, 32'd1);
        chk("sw_ram", {24'd0, ram[12'h313]}, 32'h11);

        // rob_clear in IDLE blocks the grant
        in_lsb_ready = 1'b1; op_in = F3_LB; instr_type_in = LD_TYPE;
        data_addr_in = 32'h200;
        tick();
        chk("clr_idle_a", mem_a, 32'd0);
        rob_clear = 1'b0;
        tick();
        chk("clr_idle_grant", mem_a, 32'h200);
        in_lsb_ready = 1'b0;
        tick(); tick();
        chk("clr_idle_data", cache_data_out, 32'hFFFF_FF80);

        // address wraps modulo 2^32
        fetch(32'hFFFF_FFFE, 32'h4433_2211, "wrap");

        // SB into the IO window with the buffer full for three cycles
        in_lsb_ready = 1'b1; op_in = F3_SB; instr_type_in = S_TYPE;
        data_addr_in = 32'h0003_0000; data_in = 32'h0000_00A5;
        io_buffer_full = 1'b1;
        tick();
        in_lsb_ready = 1'b0;
        chk("io_st0", {31'd0, mem_wr}, 32'd0);
        tick(); chk("io_st1", {31'd0, mem_wr}, 32'd0);
        tick(); chk("io_st2", {31'd0, mem_wr}, 32'd0);
        io_buffer_full = 1'b0;
        tick();
        chk("io_wr", {31'd0, mem_wr}, 32'd1);
        chk("io_a", mem_a, 32'h0003_0000);
        chk("io_d", {24'd0, mem_dout}, 32'hA5);
        chk("io_no_rdy", {31'd0, cache_ready}, 32'd0);
        tick();
        chk("io_end_wr", {31'd0, mem_wr}, 32'd0);
        chk("io_rdy", {31'd0, cache_ready}, 32'd1);

        // reset in the middle of a read
        ifetch_req = 1'b1; ifetch_addr = 32'h100;
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        chk("mrst_a", mem_a, 32'd0);
        chk("mrst_if_data", ifetch_data, 32'd0);
        chk("mrst_type", {25'd0, cache_instr_type}, 32'd0);
        ifetch_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        tick();

        // both pending after reset: LSB first, then fetch wins the next tie
        ifetch_req = 1'b1; ifetch_addr = 32'h100;
        in_lsb_ready = 1'b1; op_in = F3_LW; instr_type_in = LD_TYPE;
        data_addr_in = 32'h200;
        tick();
        chk("arb1_lsb", mem_a, 32'h200);
        in_lsb_ready = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        chk("arb1_rdy", {31'd0, cache_ready}, 32'd1);
        chk("arb1_data", cache_data_out, 32'hF234_7F80);
        in_lsb_ready = 1'b1; op_in = F3_LBU; data_addr_in = 32'h200;
        tick();
        chk("arb2_if", mem_a, 32'h100);
        for (int e = 1; e <= 5; e++) tick();
        chk("arb2_if_rdy", {31'd0, ifetch_ready}, 32'd1);
        chk("arb2_if_data", ifetch_data, 32'h0000_0513);
        ifetch_req = 1'b0;
        tick();
        chk("arb3_lsb", mem_a, 32'h200);
        in_lsb_ready = 1'b0;
        tick(); tick();
        chk("arb3_rdy", {31'd0, cache_ready}, 32'd1);
        chk("arb3_data", cache_data_out, 32'h0000_0080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Single owner of the byte-serial RAM/IO bus, shared between instruction fetch (32-bit reads) and the load/store buffer (LB/LH/LW/LBU/LHU/SB/SH/SW).
Round-robin arbitration grants one requester at a time and sequences each access into per-byte bus cycles.
Assembles and extends load data, then returns a one-cycle completion pulse to the winner.
Sits between the fetch unit / LSB and the top-level memory port.

Parameters:
IO_HI_BITS, 2'b11, value of addr[17:16] that marks the IO region (stores there obey io_buffer_full).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
rdy  in  1  global enable; 0 freezes all state and outputs
rob_clear  in  1  misprediction flush
io_buffer_full  in  1  UART buffer full; stalls IO stores
mem_din  in  8  read byte from RAM (valid one cycle after its address)
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1 = write, 0 = read
ifetch_req  in  1  fetch request level; held until ifetch_ready
ifetch_addr  in  32  fetch address
ifetch_ready  out  1  one-cycle pulse: ifetch_data valid
ifetch_data  out  32  fetched word, little-endian
welcome_lsb  out  1  high in IDLE when no rob_clear; LSB may present a request
in_lsb_ready  in  1  LSB request valid
op_in  in  3  funct3 width/sign code
instr_type_in  in  7  LD_TYPE or S_TYPE
data_addr_in  in  32  effective address
data_in  in  32  store data (low bytes used)
cache_ready  out  1  one-cycle pulse: LSB access complete
cache_instr_type  out  7  type of completed access
cache_data_out  out  32  extended load value; 0 for stores

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; byte counter=0; last_grant=IFETCH.
- FSM states: IDLE, READ, WRITE.
- Byte count N: op[1:0]=00 gives 1, 01 gives 2, 10 gives 4. Ifetch always uses N=4.
- Grant (IDLE, rdy=1, rob_clear=0) is taken at the clock edge.
  - Only one requester pending: it wins.
  - Both pending: the requester not granted last wins. After reset, LSB wins first.
  - Request operands are latched at grant; requesters may change inputs afterwards.
- READ (load or ifetch):
  - Grant edge drives mem_a=A, mem_wr=0.
  - Edge k (k=1..N-1) drives mem_a=A+k.
  - Byte k is captured from mem_din at edge k+2. Data is little-endian: byte k goes to bits [8k+7:8k].
  - At edge N+1: pulse the requester's ready with final data; return to IDLE; mem_a=0.
  - LW/ifetch ready is visible in the cycle after edge 5.
- WRITE: each byte cycle drives mem_a=A+k, mem_dout=data_in[8k+7:8k], mem_wr=1.
  - IO region (addr[17:16]==IO_HI_BITS) with io_buffer_full=1: hold mem_wr=0 and do not advance k.
  - After the Nth byte is driven, the next edge sets mem_wr=0, pulses cache_ready, and returns to IDLE.
  - SW ready is visible after edge 4; SB ready after edge 1.
- Load extension:
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW passes the word through unchanged.
- cache_ready and ifetch_ready are single-cycle pulses. cache_data_out and ifetch_data hold until the next completion.
- rob_clear:
  - In READ: abort at the next edge to IDLE with no ready pulse, mem_wr=0. Captured bytes are discarded.
  - In WRITE: ignored. A committed store always completes.
  - In IDLE: no grant that edge.
- rdy=0: no state change, outputs held. A pending ready pulse is extended until the first rdy=1 edge.
- Address arithmetic A+k is 32-bit and wraps modulo 2^32.

Decomposition:
- Shared package (config.v): LD_TYPE and S_TYPE type codes.
- Shared package (config.v): funct3 width codes (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Shared package (config.v): MEM_IDLE, MEM_READ, MEM_WRITE state encodings.
- Shared package (config.v): IO region constant.
- Sub-module mem_load_ext: combinational sign/zero extension (op, raw word) -> 32-bit value.

Test Plan:
1. ifetch_req, ifetch_addr=0x100, RAM[0x100..0x103]=13 05 00 00 -> mem_a shows 0x100..0x103; ifetch_ready pulse after edge 5; ifetch_data=0x00000513.
2. LSB LB at 0x200, RAM=0x80 -> cache_data_out=0xFFFFFF80. LBU at 0x200 -> 0x00000080. LH at 0x200, RAM[0x201]=0x7F -> 0x00007F80. Each returns cache_instr_type=LD_TYPE.
3. SH data_in=0xDEADBEEF at 0x300 -> two write cycles: (0x300, 0xEF, wr=1), (0x301, 0xBE, wr=1); cache_ready pulse; cache_data_out=0.
4. ifetch and LSB LW requested in the same IDLE cycle after reset -> LSB served first, then ifetch. Repeat with both pending again -> ifetch first.
5. rob_clear at the third cycle of an LW -> back to IDLE, no cache_ready. rob_clear during an SW -> all 4 bytes written, cache_ready pulses.
6. SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those cycles, then one write cycle, then cache_ready. Drop rst mid-READ -> all outputs 0 immediately.
